// File: rtl/elastic_skip_writer.sv
// elastic_skip_writer
// Write-side rate-match stage in front of the dual-clock elastic buffer.
// Accepts a valid/ready symbol stream and drives the buffer write port,
// deleting SKIP symbols when the buffer fill count is high and duplicating
// them when it is low. Payload symbols are never dropped or reordered.
//
// Handshake: a symbol transfers on a wr_clk edge where in_valid && in_ready;
// in_valid must stay high with stable in_data until that transfer happens.
// The buffer side takes a symbol on every edge where eb_wr_en is high.
//
// Optional feature: define ELASTIC_SKIP_WRITER_STATS_EN to get live
// saturating drop/insert counters; otherwise both counter ports read 0.
module elastic_skip_writer #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    DEPTH       = 4,
  parameter int                    CNT_WIDTH   = $clog2(DEPTH + 1),
  parameter logic [DATA_WIDTH-1:0] SKIP_SYMBOL = DATA_WIDTH'(8'hBC),
  parameter int                    HIGH_WATER  = 3,
  parameter int                    LOW_WATER   = 1
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  rm_enable,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  eb_wr_en,
  output logic [DATA_WIDTH-1:0] eb_wr_data,
  input  logic                  eb_wr_full,
  input  logic [CNT_WIDTH-1:0]  eb_wr_count,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           ins_cnt
);

  localparam logic [CNT_WIDTH-1:0] HIGH_CNT = CNT_WIDTH'(HIGH_WATER);
  localparam logic [CNT_WIDTH-1:0] LOW_CNT  = CNT_WIDTH'(LOW_WATER);

  typedef enum logic {
    PASS = 1'b0,
    DUP  = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    out_vld;
  logic                    out_vld_nxt;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [DATA_WIDTH-1:0]   out_data_nxt;

  logic pop;
  logic accept;
  logic is_skip;
  logic del_hit;
  logic dup_hit;

  // The held symbol leaves whenever the buffer has room.
  assign pop        = out_vld & ~eb_wr_full;
  assign eb_wr_en   = pop;
  assign eb_wr_data = out_data;

  // New symbols are taken only in PASS and only if the register frees up.
  assign in_ready = (state == PASS) & (~out_vld | pop);
  assign accept   = in_valid & in_ready;

  // Fill count is used as sampled; synchronizer lag is not compensated.
  // LOW_WATER < HIGH_WATER keeps delete and duplicate mutually exclusive.
  assign is_skip = rm_enable & (in_data == SKIP_SYMBOL);
  assign del_hit = accept & is_skip & (eb_wr_count >= HIGH_CNT);
  assign dup_hit = accept & is_skip & (eb_wr_count <= LOW_CNT);

  // Next-state and output-register update; a load wins over a pop clear.
  always_comb begin
    state_nxt    = state;
    out_vld_nxt  = out_vld;
    out_data_nxt = out_data;
    case (state)
      PASS: begin
        if (accept && !del_hit) begin
          out_vld_nxt  = 1'b1;
          out_data_nxt = in_data;
          if (dup_hit) begin
            state_nxt = DUP;
          end
        end else if (pop) begin
          out_vld_nxt = 1'b0;
        end
      end
      DUP: begin
        // First copy leaves on pop; the register keeps SKIP as the duplicate.
        if (pop) begin
          out_data_nxt = SKIP_SYMBOL;
          state_nxt    = PASS;
        end
      end
      default: begin
        state_nxt = PASS;
      end
    endcase
  end

  // State and output register; reset discards any held or pending symbol.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state    <= PASS;
      out_vld  <= 1'b0;
      out_data <= '0;
    end else begin
      state    <= state_nxt;
      out_vld  <= out_vld_nxt;
      out_data <= out_data_nxt;
    end
  end

`ifdef ELASTIC_SKIP_WRITER_STATS_EN
  logic [15:0] drop_q;
  logic [15:0] ins_q;

  // Saturating counters of deleted and inserted SKIPs.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      drop_q <= '0;
      ins_q  <= '0;
    end else begin
      if (del_hit && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
      if ((state == DUP) && pop && (ins_q != 16'hFFFF)) begin
        ins_q <= ins_q + 16'd1;
      end
    end
  end

  assign drop_cnt = drop_q;
  assign ins_cnt  = ins_q;
`else
  assign drop_cnt = '0;
  assign ins_cnt  = '0;
`endif

endmodule

// File: tb/tb_elastic_skip_writer.sv
// Directed testbench for elastic_skip_writer: passthrough, deletion,
// insertion, backpressure, reset during a pending duplicate, and counter
// saturation. Written symbols are checked in order against exp_q.
module tb_elastic_skip_writer;

  localparam int DW = 8;
  localparam int CW = 3;
  localparam logic [DW-1:0] SKIP = 8'hBC;
`ifdef ELASTIC_SKIP_WRITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Clock and reset
  logic          wr_clk      = 1'b0;
  logic          wr_rst_n    = 1'b0;
  logic          rm_enable   = 1'b0;
  logic          in_valid    = 1'b0;
  logic [DW-1:0] in_data     = '0;
  logic          in_ready;
  logic          eb_wr_en;
  logic [DW-1:0] eb_wr_data;
  logic          eb_wr_full  = 1'b0;
  logic [CW-1:0] eb_wr_count = 3'd2;
  logic [15:0]   drop_cnt;
  logic [15:0]   ins_cnt;

  always #5 wr_clk = ~wr_clk;

  elastic_skip_writer dut (
    .wr_clk      (wr_clk),
    .wr_rst_n    (wr_rst_n),
    .rm_enable   (rm_enable),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .eb_wr_en    (eb_wr_en),
    .eb_wr_data  (eb_wr_data),
    .eb_wr_full  (eb_wr_full),
    .eb_wr_count (eb_wr_count),
    .drop_cnt    (drop_cnt),
    .ins_cnt     (ins_cnt)
  );

  // Scoreboard state
  logic [DW-1:0] exp_q[$];
  int n_checks  = 0;
  int n_pass    = 0;
  int extra_wr  = 0;
  int stalls    = 0;
  int timeouts  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] stat_exp(input logic [15:0] n);
    return STATS ? n : 16'h0000;
  endfunction

  // Write monitor, sampled mid-cycle
  always @(negedge wr_clk) begin
    if (eb_wr_en) begin
      if (exp_q.size() == 0) begin
        extra_wr++;
      end else begin
        check("wr_data", 32'(eb_wr_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks: called and returning at posedge + 1
  task automatic send(input logic [DW-1:0] d);
    int w;
    bit done;
    in_valid = 1'b1;
    in_data  = d;
    w        = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge wr_clk);
      done = in_ready;
      @(posedge wr_clk);
      #1;
      if (!done) begin
        w++;
        if (w >= 20) begin
          timeouts++;
          done = 1'b1;
        end
      end
    end
    stalls += w;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge wr_clk);
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wr_en", 32'(eb_wr_en), 32'd0);
    check("rst_wr_data", 32'(eb_wr_data), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_ins", 32'(ins_cnt), 32'd0);
    repeat (2) @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
    idle(1);

    // Passthrough: rate matching off, SKIPs pass too
    rm_enable   = 1'b0;
    eb_wr_count = 3'd2;
    stalls      = 0;
    for (int i = 1; i <= 16; i++) exp_q.push_back(DW'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(SKIP);
    for (int i = 1; i <= 16; i++) send(DW'(i));
    for (int i = 0; i < 4; i++) send(SKIP);
    idle(1);
    check("pt_latency", 32'(exp_q.size()), 32'd0);
    check("pt_stalls", 32'(stalls), 32'd0);
    idle(2);
    check("pt_drop", 32'(drop_cnt), 32'd0);
    check("pt_ins", 32'(ins_cnt), 32'd0);

    // Deletion at high water, back-to-back SKIPs
    rm_enable   = 1'b1;
    eb_wr_count = 3'd3;
    stalls      = 0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send(8'h11);
    send(SKIP);
    send(SKIP);
    send(8'h22);
    idle(1);
    check("del_drain", 32'(exp_q.size()), 32'd0);
    check("del_stalls", 32'(stalls), 32'd0);
    check("del_drop", 32'(drop_cnt), 32'(stat_exp(16'd2)));
    check("del_ins", 32'(ins_cnt), 32'd0);

    // Insertion at low water: one bubble after the SKIP
    eb_wr_count = 3'd1;
    stalls      = 0;
    exp_q.push_back(8'h33);
    exp_q.push_back(SKIP);
    exp_q.push_back(SKIP);
    exp_q.push_back(8'h44);
    send(8'h33);
    send(SKIP);
    send(8'h44);
    idle(1);
    check("ins_drain", 32'(exp_q.size()), 32'd0);
    check("ins_stalls", 32'(stalls), 32'd1);
    check("ins_ins", 32'(ins_cnt), 32'(stat_exp(16'd1)));
    check("ins_drop", 32'(drop_cnt), 32'(stat_exp(16'd2)));
    idle(2);

    // Backpressure: 0x55 held while full, 0x66 waits behind it
    eb_wr_count = 3'd2;
    eb_wr_full  = 1'b1;
    in_valid    = 1'b1;
    in_data     = 8'h55;
    @(negedge wr_clk);
    check("bp_first_rdy", 32'(in_ready), 32'd1);
    @(posedge wr_clk);
    #1;
    in_data = 8'h66;
    repeat (5) begin
      @(negedge wr_clk);
      check("bp_wr_en", 32'(eb_wr_en), 32'd0);
      check("bp_data", 32'(eb_wr_data), 32'h55);
      check("bp_rdy", 32'(in_ready), 32'd0);
      @(posedge wr_clk);
      #1;
    end
    eb_wr_full = 1'b0;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h66);
    @(negedge wr_clk);
    check("bp_rel_rdy", 32'(in_ready), 32'd1);
    @(posedge wr_clk);
    #1;
    in_valid = 1'b0;
    @(negedge wr_clk);
    check("bp_next_en", 32'(eb_wr_en), 32'd1);
    @(posedge wr_clk);
    #1;
    check("bp_drain", 32'(exp_q.size()), 32'd0);
    idle(2);

    // Reset while a duplicate is pending
    eb_wr_count = 3'd1;
    exp_q.push_back(8'h77);
    send(8'h77);
    send(SKIP);
    in_valid = 1'b0;
    wr_rst_n = 1'b0;
    #1;
    check("rdup_wr_en", 32'(eb_wr_en), 32'd0);
    check("rdup_rdy", 32'(in_ready), 32'd1);
    check("rdup_data", 32'(eb_wr_data), 32'd0);
    check("rdup_drop", 32'(drop_cnt), 32'd0);
    check("rdup_ins", 32'(ins_cnt), 32'd0);
    repeat (2) @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
    idle(3);
    check("rdup_drain", 32'(exp_q.size()), 32'd0);
    check("rdup_extra", 32'(extra_wr), 32'd0);

    // Saturation: 0xFFFF + 3 deletions
    rm_enable   = 1'b1;
    eb_wr_count = 3'd3;
    in_valid    = 1'b1;
    in_data     = SKIP;
    repeat (65534) @(posedge wr_clk);
    #1;
    check("sat_below", 32'(drop_cnt), 32'(stat_exp(16'hFFFE)));
    repeat (4) @(posedge wr_clk);
    #1;
    in_valid = 1'b0;
    check("sat_drop", 32'(drop_cnt), 32'(stat_exp(16'hFFFF)));
    check("sat_ins", 32'(ins_cnt), 32'd0);
    idle(2);
    check("sat_extra", 32'(extra_wr), 32'd0);
    check("timeouts", 32'(timeouts), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
